// File: rtl/mc_ctrl_pkg.sv
// Shared control encodings for the multicycle controller and fetch unit.
// States, next-PC selects, opcodes, functs and datapath select codes.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   localparam logic [1:0] NPC_NORMAL    = 2'd0;
   localparam logic [1:0] NPC_RELATIVE  = 2'd1;
   localparam logic [1:0] NPC_NRELATIVE = 2'd2;
   localparam logic [1:0] NPC_REG       = 2'd3;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_JR   = 6'h08;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_OR  = 3'd2;
   localparam logic [2:0] ALU_LUI = 3'd3;

   localparam logic [1:0] EXT_ZERO = 2'd0;
   localparam logic [1:0] EXT_SIGN = 2'd1;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   typedef enum logic [3:0] {
      I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW,
      I_SW, I_BEQ, I_J, I_JAL, I_JR, I_ILL
   } iclass_e;

   typedef struct packed {
      logic [1:0] npc_sel;
      logic       pc_write;
      logic       rgs_ins_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic       alu_src;
      logic [2:0] alu_op;
      logic [1:0] ext_op;
      logic       mem_write;
      logic       mem_req;
      logic [1:0] mem_to_reg;
      logic       illegal;
   } ctl_t;

endpackage

// File: rtl/mc_decode.sv
// Instruction classifier: op/funct to instruction class.
// Funct only matters for op=0; anything unrecognised is illegal.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output iclass_e    iclass,
   output logic       illegal
);

   logic rtype;

   assign rtype = (op == OP_RTYPE);

   always_comb begin
      iclass = I_ILL;
      unique case (1'b1)
         (rtype && funct == FN_ADDU): iclass = I_ADDU;
         (rtype && funct == FN_SUBU): iclass = I_SUBU;
         (rtype && funct == FN_JR):   iclass = I_JR;
         (op == OP_ORI):              iclass = I_ORI;
         (op == OP_LUI):              iclass = I_LUI;
         (op == OP_LW):               iclass = I_LW;
         (op == OP_SW):               iclass = I_SW;
         (op == OP_BEQ):              iclass = I_BEQ;
         (op == OP_J):                iclass = I_J;
         (op == OP_JAL):              iclass = I_JAL;
         default:                     iclass = I_ILL;
      endcase
   end

   assign illegal = (iclass == I_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Outputs decode from the registered state and current inputs.
module mc_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [1:0] npc_sel,
   output logic       pc_write,
   output logic       rgs_ins_write,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic       alu_src,
   output logic [2:0] alu_op,
   output logic [1:0] ext_op,
   output logic       mem_write,
   output logic       mem_req,
   output logic [1:0] mem_to_reg,
   output logic [2:0] state,
   output logic       illegal
);

   state_e  state_q;
   state_e  state_n;
   logic    run_q;
   iclass_e iclass;
   logic    bad;
   ctl_t    ctl;
   ctl_t    ctl_o;

   mc_decode u_decode (
      .op      (op),
      .funct   (funct),
      .iclass  (iclass),
      .illegal (bad)
   );

   // run_q holds the FSM in a silent FETCH until the first edge after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         run_q   <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (run_q)
            state_q <= state_n;
      end
   end

   always_comb begin
      ctl     = '0;
      state_n = S_FETCH;
      unique case (state_q)
         S_FETCH: begin
            ctl.rgs_ins_write = 1'b1;
            ctl.pc_write      = 1'b1;
            ctl.npc_sel       = NPC_NORMAL;
            state_n           = S_DECODE;
         end
         S_DECODE: begin
            state_n     = bad ? S_FETCH : S_EXEC;
            ctl.illegal = bad;
            case (iclass)
               I_J: begin
                  ctl.pc_write = 1'b1;
                  ctl.npc_sel  = NPC_NRELATIVE;
                  state_n      = S_FETCH;
               end
               I_JAL: begin
                  ctl.pc_write   = 1'b1;
                  ctl.npc_sel    = NPC_NRELATIVE;
                  ctl.reg_write  = 1'b1;
                  ctl.reg_dst    = DST_RA;
                  ctl.mem_to_reg = WB_PC;
                  state_n        = S_FETCH;
               end
               I_JR: begin
                  ctl.pc_write = 1'b1;
                  ctl.npc_sel  = NPC_REG;
                  state_n      = S_FETCH;
               end
               default: ;
            endcase
         end
         S_EXEC: begin
            case (iclass)
               I_ADDU: begin
                  ctl.alu_op = ALU_ADD;
                  state_n    = S_WB;
               end
               I_SUBU: begin
                  ctl.alu_op = ALU_SUB;
                  state_n    = S_WB;
               end
               I_ORI: begin
                  ctl.alu_src = 1'b1;
                  ctl.ext_op  = EXT_ZERO;
                  ctl.alu_op  = ALU_OR;
                  state_n     = S_WB;
               end
               I_LUI: begin
                  ctl.alu_src = 1'b1;
                  ctl.alu_op  = ALU_LUI;
                  state_n     = S_WB;
               end
               I_LW, I_SW: begin
                  ctl.alu_src = 1'b1;
                  ctl.ext_op  = EXT_SIGN;
                  ctl.alu_op  = ALU_ADD;
                  state_n     = S_MEM;
               end
               I_BEQ: begin
                  ctl.alu_op   = ALU_SUB;
                  ctl.npc_sel  = NPC_RELATIVE;
                  ctl.pc_write = zero;
                  state_n      = S_FETCH;
               end
               default: state_n = S_FETCH;
            endcase
         end
         S_MEM: begin
            ctl.mem_req   = 1'b1;
            ctl.mem_write = (iclass == I_SW);
            if (!mem_ready)
               state_n = S_MEM;
            else if (iclass == I_LW)
               state_n = S_WB;
            else
               state_n = S_FETCH;
         end
         S_WB: begin
            ctl.reg_write = 1'b1;
            ctl.reg_dst   = DST_RT;
            ctl.mem_to_reg = WB_ALU;
            if (iclass == I_ADDU || iclass == I_SUBU)
               ctl.reg_dst = DST_RD;
            if (iclass == I_LW)
               ctl.mem_to_reg = WB_MEM;
            state_n = S_FETCH;
         end
         default: begin
            ctl     = '0;
            state_n = S_FETCH;
         end
      endcase
   end

   assign ctl_o = run_q ? ctl : '0;

   assign npc_sel       = ctl_o.npc_sel;
   assign pc_write      = ctl_o.pc_write;
   assign rgs_ins_write = ctl_o.rgs_ins_write;
   assign reg_write     = ctl_o.reg_write;
   assign reg_dst       = ctl_o.reg_dst;
   assign alu_src       = ctl_o.alu_src;
   assign alu_op        = ctl_o.alu_op;
   assign ext_op        = ctl_o.ext_op;
   assign mem_write     = ctl_o.mem_write;
   assign mem_req       = ctl_o.mem_req;
   assign mem_to_reg    = ctl_o.mem_to_reg;
   assign illegal       = ctl_o.illegal;
   assign state         = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected cycle lists from the ISA rules,
// one negedge compare process, directed scenarios then random programs.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic [1:0] npc_sel;
   logic       pc_write;
   logic       rgs_ins_write;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic       alu_src;
   logic [2:0] alu_op;
   logic [1:0] ext_op;
   logic       mem_write;
   logic       mem_req;
   logic [1:0] mem_to_reg;
   logic [2:0] state;
   logic       illegal;

   mc_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .op            (op),
      .funct         (funct),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .npc_sel       (npc_sel),
      .pc_write      (pc_write),
      .rgs_ins_write (rgs_ins_write),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .alu_src       (alu_src),
      .alu_op        (alu_op),
      .ext_op        (ext_op),
      .mem_write     (mem_write),
      .mem_req       (mem_req),
      .mem_to_reg    (mem_to_reg),
      .state         (state),
      .illegal       (illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] npc;
      logic       pcw;
      logic       irw;
      logic       rw;
      logic [1:0] rdst;
      logic       asrc;
      logic [2:0] aop;
      logic [1:0] ext;
      logic       mw;
      logic       mreq;
      logic [1:0] m2r;
      logic       ill;
   } obs_t;

   int   checks = 0;
   int   failures = 0;
   obs_t exp_q[$];
   logic [2:0] hist[$];
   logic chk_en = 1'b0;
   int   cyc_n, mreq_cnt, mw_cnt, rw_cnt, ill_cnt, n;
   obs_t ce, ca;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && exp_q.size() > 0) begin
         ce = exp_q.pop_front();
         ca = {state, npc_sel, pc_write, rgs_ins_write, reg_write,
               reg_dst, alu_src, alu_op, ext_op, mem_write, mem_req,
               mem_to_reg, illegal};
         chk("cycle", 32'(ca), 32'(ce));
         hist.push_back(state);
         if (mem_req)   mreq_cnt++;
         if (mem_write) mw_cnt++;
         if (reg_write) rw_cnt++;
         if (illegal)   ill_cnt++;
      end
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [31:0] hcode();
      logic [31:0] h = 0;
      foreach (hist[i]) h = (h << 4) | 32'(hist[i]);
      return h;
   endfunction

   task automatic cyc(input obs_t e, input logic z, input logic r);
      zero      = z;
      mem_ready = r;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   // k: 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 j 8 jal 9 jr 10 illegal
   task automatic do_instr(input int k, input logic z, input int waits,
                           input logic [5:0] iop, input logic [5:0] ifn);
      obs_t e;
      cyc_n = 0; mreq_cnt = 0; mw_cnt = 0; rw_cnt = 0; ill_cnt = 0;
      hist.delete();
      funct = 6'($urandom);
      case (k)
         0: begin op = 6'h00; funct = 6'h21; end
         1: begin op = 6'h00; funct = 6'h23; end
         2: op = 6'h0d;
         3: op = 6'h0f;
         4: op = 6'h23;
         5: op = 6'h2b;
         6: op = 6'h04;
         7: op = 6'h02;
         8: op = 6'h03;
         9: begin op = 6'h00; funct = 6'h08; end
         default: begin op = iop; funct = ifn; end
      endcase
      e = '0; e.irw = 1; e.pcw = 1;
      cyc(e, rb(), rb());
      e = '0; e.st = 1;
      if (k == 7) begin e.pcw = 1; e.npc = 2; end
      if (k == 8) begin
         e.pcw = 1; e.npc = 2; e.rw = 1; e.rdst = 2; e.m2r = 2;
      end
      if (k == 9) begin e.pcw = 1; e.npc = 3; end
      if (k == 10) e.ill = 1;
      cyc(e, rb(), rb());
      if (k >= 7) return;
      e = '0; e.st = 2;
      if (k == 1 || k == 6) e.aop = 1;
      if (k == 2) begin e.asrc = 1; e.aop = 2; end
      if (k == 3) begin e.asrc = 1; e.aop = 3; end
      if (k == 4 || k == 5) begin e.asrc = 1; e.ext = 1; end
      if (k == 6) begin e.npc = 1; e.pcw = z; end
      cyc(e, (k == 6) ? z : rb(), rb());
      if (k == 6) return;
      if (k == 4 || k == 5) begin
         e = '0; e.st = 3; e.mreq = 1; e.mw = (k == 5);
         for (int i = 0; i < waits; i++) cyc(e, rb(), 1'b0);
         cyc(e, rb(), 1'b1);
         if (k == 5) return;
      end
      e = '0; e.st = 4; e.rw = 1;
      if (k <= 1) e.rdst = 1;
      if (k == 4) e.m2r = 1;
      cyc(e, rb(), rb());
   endtask

   function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00)
         return f == 6'h21 || f == 6'h23 || f == 6'h08;
      return o == 6'h0d || o == 6'h0f || o == 6'h23 || o == 6'h2b ||
             o == 6'h04 || o == 6'h02 || o == 6'h03;
   endfunction

   initial begin
      logic [5:0] ro, rf;
      int k;
      reset = 1'b0; op = 0; funct = 0; zero = 0; mem_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_irw", 32'(rgs_ins_write), 0);
      chk("rst_pcw", 32'(pc_write), 0);
      #2 reset = 1'b1;
      #1 chk("rel_pcw_pre_edge", 32'(pc_write), 0);
      @(posedge clk);
      #1;
      chk("rel_irw", 32'(rgs_ins_write), 1);
      chk("rel_pcw", 32'(pc_write), 1);
      chk("rel_state", 32'(state), 0);
      chk_en = 1'b1;

      do_instr(0, 0, 0, 0, 0);
      chk("addu_cycles", 32'(cyc_n), 4);
      chk("addu_states", hcode(), 32'h0124);
      chk("addu_rw_cnt", 32'(rw_cnt), 1);

      do_instr(4, 0, 2, 0, 0);
      chk("lw_cycles", 32'(cyc_n), 7);
      chk("lw_states", hcode(), 32'h0123334);
      chk("lw_mreq_cnt", 32'(mreq_cnt), 3);
      chk("lw_mw_cnt", 32'(mw_cnt), 0);

      do_instr(6, 1, 0, 0, 0);
      chk("beq1_cycles", 32'(cyc_n), 3);
      do_instr(6, 0, 0, 0, 0);
      chk("beq0_cycles", 32'(cyc_n), 3);
      chk("beq0_states", hcode(), 32'h012);

      do_instr(8, 0, 0, 0, 0);
      chk("jal_cycles", 32'(cyc_n), 2);
      chk("jal_rw_cnt", 32'(rw_cnt), 1);

      do_instr(10, 0, 0, 6'h3f, 6'h00);
      chk("ill_cycles", 32'(cyc_n), 2);
      chk("ill_pulses", 32'(ill_cnt), 1);
      chk("ill_rw_cnt", 32'(rw_cnt), 0);

      // reset mid-EXEC
      chk_en = 1'b0;
      op = 6'h00; funct = 6'h21;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("exec_state", 32'(state), 2);
      #2 reset = 1'b0;
      #1;
      chk("rst_exec_state", 32'(state), 0);
      chk("rst_exec_en", {27'd0, rgs_ins_write, pc_write, reg_write,
                          mem_write, mem_req}, 0);
      @(posedge clk); #1;
      #2 reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_exec_irw_pcw", {30'd0, rgs_ins_write, pc_write}, 3);

      // reset during a sw MEM wait
      op = 6'h2b; mem_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("sw_wait_state", 32'(state), 3);
      chk("sw_wait_mw", 32'(mem_write), 1);
      #2 reset = 1'b0;
      #1;
      chk("rst_mem_state", 32'(state), 0);
      chk("rst_mem_en", {30'd0, mem_write, mem_req}, 0);
      #3 reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_mem_irw", 32'(rgs_ins_write), 1);
      chk_en = 1'b1;

      do_instr(0, 0, 0, 0, 0);
      chk("post_rst_addu_states", hcode(), 32'h0124);

      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 10);
         ro = 0; rf = 0;
         if (k == 10) begin
            do begin
               ro = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom);
               rf = 6'($urandom);
            end while (is_legal(ro, rf));
         end
         do_instr(k, rb(), $urandom_range(0, 3), ro, rf);
      end

      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low; the FSM is in reset while low
  op  in  6  rgs_ins[31:26] from the fetch unit
  funct  in  6  rgs_ins[5:0]
  zero  in  1  ALU result-equals-zero flag
  mem_ready  in  1  data-memory access-complete handshake
  npc_sel  out  2  next-PC select to the fetch unit
  pc_write  out  1  PC load enable
  rgs_ins_write  out  1  instruction-register load enable
  reg_write  out  1  register-file write enable
  reg_dst  out  2  write address: 0=rt, 1=rd, 2=$31
  alu_src  out  1  0=rt data, 1=extended immediate
  alu_op  out  3  0=add, 1=sub, 2=or, 3=lui-shift
  ext_op  out  2  0=zero-extend, 1=sign-extend
  mem_write  out  1  data-memory write enable
  mem_req  out  1  data-memory access request
  mem_to_reg  out  2  write-back source: 0=ALU, 1=memory, 2=PC
  state  out  3  current FSM state (debug)
  illegal  out  1  one-cycle pulse on an unsupported opcode or funct

Function
REQ-002 The FSM states SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-003 All outputs SHALL be combinational in the registered state, op, funct, zero and mem_ready; unlisted outputs are 0 in every state.
REQ-004 In FETCH: rgs_ins_write=1, pc_write=1, npc_sel=NORMAL; next state is DECODE.
REQ-005 In DECODE: j sets pc_write=1 and npc_sel=NRELATIVE, then goes to FETCH. jal does the same and also sets reg_write=1, reg_dst=2, mem_to_reg=2. jr (op=0, funct=0x08) sets pc_write=1 and npc_sel=REG, then goes to FETCH. Every other supported instruction goes to EXEC.
REQ-006 Supported instructions: addu (0/0x21), subu (0/0x23), ori (0x0d), lui (0x0f), lw (0x23), sw (0x2b), beq (0x04), j (0x02), jal (0x03), jr (0/0x08).
REQ-007 EXEC settings and next state:
  addu/subu: alu_op add/sub, next WB.
  ori: alu_src=1, ext_op=0, alu_op=or, next WB.
  lui: alu_src=1, alu_op=lui, next WB.
  lw/sw: alu_src=1, ext_op=1, alu_op=add, next MEM.
  beq: alu_op=sub, npc_sel=RELATIVE, pc_write=zero, next FETCH.
REQ-008 In MEM: mem_req=1, and mem_write=1 for sw. The FSM holds in MEM while mem_ready=0. On mem_ready=1, lw goes to WB and sw goes to FETCH.
REQ-009 In WB: reg_write=1. R-type uses reg_dst=1 and mem_to_reg=0. ori/lui use reg_dst=0 and mem_to_reg=0. lw uses reg_dst=0 and mem_to_reg=1. Next state is FETCH.
REQ-010 An unsupported op or funct in DECODE SHALL pulse illegal=1 and return to FETCH with no register, memory or PC write; the PC has already advanced by 4.
REQ-011 CPI SHALL be: j/jal/jr 2, beq 3, R-type/ori/lui/sw 4 (sw with no wait), lw 5 (no wait), plus one cycle per mem_ready=0 cycle.
REQ-012 A branch offset SHALL be taken relative to PC+4, because PC is incremented in FETCH before the EXEC branch.
REQ-013 Unreachable state encodings SHALL drive all outputs to 0 and go to FETCH.

Reset
REQ-014 While reset=0, state SHALL be FETCH immediately (asynchronous), independent of clk.
REQ-015 During reset, all write/request outputs SHALL be 0, even though FETCH decode would assert them; they become active on the first clk edge after reset rises.
REQ-016 A reset asserted in any state, including a MEM wait, SHALL abort the instruction; no partial write completes after reset releases.

Structure
REQ-017 State encodings, npc_sel codes (NORMAL=0, RELATIVE=1, NRELATIVE=2, REG=3), opcode/funct constants and the alu_op, reg_dst and mem_to_reg codes SHALL live in the shared defines file used by the fetch unit.
REQ-018 The block SHALL have one sub-module, mc_decode: combinational decoding of op/funct into an instruction class and illegal flag. The FSM and output logic stay in mc_ctrl.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  Reset low mid-EXEC -> state=0 and all enables 0 immediately; after release, first edge gives rgs_ins_write=1, pc_write=1.
  addu sequence -> states 0,1,2,4,0; reg_write=1 with reg_dst=1 only in WB.
  lw with mem_ready low for 2 cycles -> states 0,1,2,3,3,3,4,0; mem_req=1 for 3 cycles; mem_write=0 throughout.
  beq with zero=1 -> pc_write=1, npc_sel=1 in EXEC; with zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
  jal -> 2 cycles; in DECODE pc_write=1, npc_sel=2, reg_write=1, reg_dst=2, mem_to_reg=2.
  op=0x3f -> illegal pulse for 1 cycle in DECODE, no write enables, next state FETCH.
